// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: merges the in-order W-stage write with buffered
// long-latency results onto the single GPR write port, and keeps a per-register
// pending scoreboard so decode can stall readers of not-yet-written registers.
module gpr_wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic        l_valid,
    input  logic [4:0]  l_addr,
    input  logic [31:0] l_data,
    output logic        l_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic        busy1,
    output logic        busy2,
    output logic        RegWriteW,
    output logic [4:0]  A3,
    output logic [31:0] WD
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:1]   pending;
    logic [31:0]   pending_vec;

    logic        push;
    logic        pop;
    logic        p_sel;
    logic        fifo_wr;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // Source selection: pipeline wins unless it targets $0; otherwise drain the FIFO head
    always_comb begin
        l_ready     = (count != CW'(DEPTH));
        push        = l_valid && l_ready;
        p_sel       = p_we && (p_addr != 5'd0);
        pop         = !p_sel && (count != '0);
        head_addr   = fifo_addr[rd_ptr];
        head_data   = fifo_data[rd_ptr];
        fifo_wr     = pop && (head_addr != 5'd0);
        pending_vec = {pending, 1'b0};
    end

    // Busy also covers a FIFO write being selected this cycle, before it reaches the GPR
    always_comb begin
        busy1 = pending_vec[A1] || (fifo_wr && (head_addr == A1) && (A1 != 5'd0));
        busy2 = pending_vec[A2] || (fifo_wr && (head_addr == A2) && (A2 != 5'd0));
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= l_addr;
            fifo_data[wr_ptr] <= l_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered GPR write port; address/data hold when nothing is written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            A3        <= 5'd0;
            WD        <= 32'd0;
        end else if (p_sel) begin
            RegWriteW <= 1'b1;
            A3        <= p_addr;
            WD        <= p_data;
        end else if (fifo_wr) begin
            RegWriteW <= 1'b1;
            A3        <= head_addr;
            WD        <= head_data;
        end else begin
            RegWriteW <= 1'b0;
        end
    end

    // Pending scoreboard: a new issue takes precedence over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (iss_valid && (iss_addr == 5'(i))) begin
                    pending[i] <= 1'b1;
                end else if (fifo_wr && (head_addr == 5'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

endmodule
